vga_pattern_timing: RTL and testbench
=====================================

// Module: vga_pattern_timing
// PURPOSE
//  Parametrised VGA/SVGA raster timing generator with built-in test-pattern source.
//  Sits between the pixel-clock domain and the DAC/resistor-ladder pins.
//  Replaces fixed 800x600 checkerboard generation with:
//  - configurable timings, sync polarity, colour depth and pixel-enable;
//  - frame-latched pattern modes, plus a frame counter for animated patterns.
// PARAMETERS
//  H_ACTIVE   800  visible pixels per line
//  H_FP       56   horizontal front porch (pixels)
//  H_SYNC     120  horizontal sync pulse (pixels)
//  H_BP       64   horizontal back porch (pixels)
//  V_ACTIVE   600  visible lines per frame
//  V_FP       37   vertical front porch (lines)
//  V_SYNC     6    vertical sync pulse (lines)
//  V_BP       23   vertical back porch (lines)
//  HS_POL     0    hsync level during pulse (0 = active-low)
//  VS_POL     0    vsync level during pulse
//  COLOR_W    1    bits per colour channel
//  CELL_LOG2  5    checkerboard cell size = 2**CELL_LOG2 pixels
//  BAR_LOG2   7    colour-bar width = 2**BAR_LOG2 pixels
//  FRAME_W    8    frame counter width
// PORTS
//  clk        in   1          pixel clock
//  rst_n      in   1          asynchronous reset, active-low
//  pix_en     in   1          pixel strobe; all state advances only when 1
//  mode       in   2          0 checker, 1 colour bars, 2 solid fg, 3 scrolling checker
//  fg_rgb     in   3*COLOR_W  foreground {r,g,b}
//  bg_rgb     in   3*COLOR_W  background {r,g,b}
//  hsync      out  1          horizontal sync
//  vsync      out  1          vertical sync
//  de         out  1          data enable (visible pixel)
//  red/green/blue out COLOR_W each  pixel colour
//  frame_start out 1          one-pixel pulse on first pixel (0,0) of each frame
//  frame_cnt  out  FRAME_W    completed-frame count
// BEHAVIOUR
//  - Reset (async, rst_n=0): counters 0; mode_q 0; frame_cnt 0; de 0; rgb 0; frame_start 0.
//    Also hsync=~HS_POL, vsync=~VS_POL. Release: first pix_en processes pixel (0,0).
//  - Totals: H_TOTAL = sum of H_*; V_TOTAL = sum of V_*. Counter width = $clog2(total).
//  - Counter stepping (on each pix_en):
//    - h_cnt: 0..H_TOTAL-1, then wraps to 0.
//    - v_cnt: steps only when h_cnt wraps; range 0..V_TOTAL-1, then wraps.
//    - frame_cnt: +1 (mod 2**FRAME_W) when both counters wrap together.
//  - Sync pulse: h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC) -> hsync=HS_POL, else ~HS_POL.
//    vsync follows the same rule with the V_* parameters.
//  - Visible region: h<H_ACTIVE && v<V_ACTIVE.
//  - mode_q samples mode on the pix_en cycle where h=0, v=0.
//    A mid-frame mode change is ignored until the next frame.
//  - Pattern (visible region only; blanking forces rgb=0):
//    - m0: (x[CELL_LOG2]^y[CELL_LOG2]) ? fg : bg.
//    - m1: b = ~x[BAR_LOG2+2:BAR_LOG2]; each channel = all-ones if its bit of b is set, else 0.
//      Bar 0 is white; r=b[2], g=b[1], b=b[0].
//    - m2: fg everywhere.
//    - m3: as m0, using (x+frame_cnt) in place of x; the sum truncates to the counter width.
//  - Latency: all outputs registered, exactly 1 pix_en cycle after the counter state.
//    hsync, vsync, de, rgb and frame_start stay mutually aligned.
//  - pix_en=0: counters and outputs hold their values.
//  - frame_start: 1 for the single pix_en cycle carrying pixel (0,0); it is never asserted twice per frame.
//  - Async reset mid-line: outputs immediately return to reset values; no partial-state carry-over.
// STRUCTURE
//  - vga_pkg: mode localparams (MODE_CHECK, MODE_BARS, MODE_SOLID, MODE_SCROLL).
//    It also holds the function computing counter width from timing totals.
//  - Sub-module vga_timing_counter: one instance per axis.
//    Parameters: ACTIVE/FP/SYNC/BP/POL. Ports: clk, rst_n, step in, wrap out, cnt out,
//    active out, sync_level out.
//  - Top level: chains horizontal wrap into vertical step.
//    It also holds mode_q, frame_cnt, the pattern mux and the output register stage.
// TESTING
//  1. Defaults, pix_en=1, after reset: hsync low for exactly 120 clocks per 1040-clock line;
//     vsync low for 6 lines (6240 clocks) per 666-line frame.
//  2. Small config (H=8/1/2/1, V=4/1/1/1), m0, CELL_LOG2=1, fg=7, bg=1:
//     line 0 rgb = 1,1,7,7,1,1,7,7; de high for 8 of 12 clocks.
//  3. pix_en toggled 1/0 each clock: hsync period doubles to 2080 clocks; outputs stable on pix_en=0 cycles.
//  4. mode 0 -> 1 switched at mid-frame: rgb follows m0 until frame_start, then bars (white first bar).
//  5. m3, small config, over 3 frames: frame_cnt goes 0->1->2; checker shifts one pixel left per frame.
//  6. rst_n pulsed low mid-line: within the same clock de=0, rgb=0, sync inactive.
//     After release, frame_start is asserted on the first pix_en.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pattern/timing generator: pattern mode codes and
// helpers for sizing raster counters and picking bits out of them.
package vga_pkg;

    localparam logic [1:0] MODE_CHECK  = 2'd0;
    localparam logic [1:0] MODE_BARS   = 2'd1;
    localparam logic [1:0] MODE_SOLID  = 2'd2;
    localparam logic [1:0] MODE_SCROLL = 2'd3;

    // Width of a counter that must hold 0..total-1.
    function automatic int unsigned cnt_width(input int unsigned total);
        return (total < 2) ? 1 : $clog2(total);
    endfunction

    // Bit select that reads as 0 beyond the counter width (small rasters, wide cells).
    function automatic logic bit_at(input logic [31:0] value, input int unsigned idx);
        return (idx < 32) ? value[idx] : 1'b0;
    endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// One raster axis: wrapping position counter with active-region and sync-pulse decode.
// wrap_o is combinational so the next axis can step on the same pixel.
module vga_timing_counter
    import vga_pkg::*;
#(
    parameter int unsigned ACTIVE = 800,
    parameter int unsigned FP     = 56,
    parameter int unsigned SYNC   = 120,
    parameter int unsigned BP     = 64,
    parameter bit          POL    = 1'b0,
    localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP,
    localparam int unsigned CNT_W = cnt_width(TOTAL)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             step_i,
    output logic             wrap_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             active_o,
    output logic             sync_level_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (step_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign wrap_o       = step_i && (cnt_q == LAST);
    assign cnt_o        = cnt_q;
    assign active_o     = 32'(cnt_q) < ACTIVE;
    assign sync_level_o = ((32'(cnt_q) >= ACTIVE + FP) && (32'(cnt_q) < ACTIVE + FP + SYNC))
                          ? POL : ~POL;

endmodule

// File: rtl/vga_pattern_timing.sv
// VGA raster timing generator with frame-latched test patterns; every output is
// registered one pixel strobe after the counter state that produced it.
module vga_pattern_timing
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = 800,
    parameter int unsigned H_FP      = 56,
    parameter int unsigned H_SYNC    = 120,
    parameter int unsigned H_BP      = 64,
    parameter int unsigned V_ACTIVE  = 600,
    parameter int unsigned V_FP      = 37,
    parameter int unsigned V_SYNC    = 6,
    parameter int unsigned V_BP      = 23,
    parameter bit          HS_POL    = 1'b0,
    parameter bit          VS_POL    = 1'b0,
    parameter int unsigned COLOR_W   = 1,
    parameter int unsigned CELL_LOG2 = 5,
    parameter int unsigned BAR_LOG2  = 7,
    parameter int unsigned FRAME_W   = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 pix_en_i,
    input  logic [1:0]           mode_i,
    input  logic [3*COLOR_W-1:0] fg_rgb_i,
    input  logic [3*COLOR_W-1:0] bg_rgb_i,
    output logic                 hsync_o,
    output logic                 vsync_o,
    output logic                 de_o,
    output logic [COLOR_W-1:0]   red_o,
    output logic [COLOR_W-1:0]   green_o,
    output logic [COLOR_W-1:0]   blue_o,
    output logic                 frame_start_o,
    output logic [FRAME_W-1:0]   frame_cnt_o
);

    localparam int unsigned H_W = cnt_width(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int unsigned V_W = cnt_width(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam int unsigned RGB_W = 3 * COLOR_W;

    logic [H_W-1:0] h_cnt;
    logic [V_W-1:0] v_cnt;
    logic           h_wrap, v_wrap, h_active, v_active, h_sync, v_sync;

    vga_timing_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (HS_POL)
    ) u_h_counter (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .step_i       (pix_en_i),
        .wrap_o       (h_wrap),
        .cnt_o        (h_cnt),
        .active_o     (h_active),
        .sync_level_o (h_sync)
    );

    vga_timing_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (VS_POL)
    ) u_v_counter (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .step_i       (h_wrap),
        .wrap_o       (v_wrap),
        .cnt_o        (v_cnt),
        .active_o     (v_active),
        .sync_level_o (v_sync)
    );

    logic [1:0]         mode_q, mode_eff;
    logic [FRAME_W-1:0] frame_cnt_q;
    logic               first_px, visible, cell_sel;
    logic [H_W-1:0]     x_scroll;
    logic [2:0]         bar;
    logic [RGB_W-1:0]   rgb_d, rgb_q;
    logic               hsync_q, vsync_q, de_q, frame_start_q;

    assign first_px = (h_cnt == '0) && (v_cnt == '0);
    assign visible  = h_active && v_active;

    // The first pixel of a frame already uses the newly sampled mode.
    always_comb begin
        mode_eff = first_px ? mode_i : mode_q;
        x_scroll = h_cnt + H_W'(frame_cnt_q);
        bar      = ~{bit_at(32'(h_cnt), BAR_LOG2 + 2), bit_at(32'(h_cnt), BAR_LOG2 + 1),
                     bit_at(32'(h_cnt), BAR_LOG2)};
        cell_sel = 1'b0;
        rgb_d    = '0;
        case (mode_eff)
            MODE_CHECK:  cell_sel = bit_at(32'(h_cnt), CELL_LOG2) ^ bit_at(32'(v_cnt), CELL_LOG2);
            MODE_SCROLL: cell_sel = bit_at(32'(x_scroll), CELL_LOG2)
                                    ^ bit_at(32'(v_cnt), CELL_LOG2);
            default:     cell_sel = 1'b1;
        endcase
        if (visible) begin
            if (mode_eff == MODE_BARS) begin
                rgb_d = {{COLOR_W{bar[2]}}, {COLOR_W{bar[1]}}, {COLOR_W{bar[0]}}};
            end else begin
                rgb_d = cell_sel ? fg_rgb_i : bg_rgb_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_q        <= MODE_CHECK;
            frame_cnt_q   <= '0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            de_q          <= 1'b0;
            rgb_q         <= '0;
            frame_start_q <= 1'b0;
        end else if (pix_en_i) begin
            if (first_px) begin
                mode_q <= mode_i;
            end
            if (h_wrap && v_wrap) begin
                frame_cnt_q <= frame_cnt_q + FRAME_W'(1);
            end
            hsync_q       <= h_sync;
            vsync_q       <= v_sync;
            de_q          <= visible;
            rgb_q         <= rgb_d;
            frame_start_q <= first_px;
        end
    end

    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign de_o          = de_q;
    assign red_o         = rgb_q[RGB_W-1 -: COLOR_W];
    assign green_o       = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign blue_o        = rgb_q[COLOR_W-1:0];
    assign frame_start_o = frame_start_q;
    assign frame_cnt_o   = frame_cnt_q;

endmodule

// File: tb/tb_vga_pattern_timing.sv
// Randomised bench for vga_pattern_timing on a small raster, checked against a
// pixel-position reference model plus a few directed spot checks.
module tb_vga_pattern_timing;

    localparam int H_ACT = 8, H_FP = 1, H_SY = 2, H_BP = 1;
    localparam int V_ACT = 4, V_FP = 1, V_SY = 1, V_BP = 1;
    localparam int H_TOT = H_ACT + H_FP + H_SY + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SY + V_BP;
    localparam bit HS_P = 1'b0, VS_P = 1'b1;
    localparam int CELL = 1, BAR = 1;
    localparam int XMOD = 1 << $clog2(H_TOT);

    logic       clk = 1'b0, rst_n = 1'b1, pix_en = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [2:0] fg = 3'd7, bg = 3'd1;
    logic       hsync, vsync, de, red, green, blue, frame_start;
    logic [7:0] frame_cnt;

    vga_pattern_timing #(
        .H_ACTIVE (H_ACT), .H_FP (H_FP), .H_SYNC (H_SY), .H_BP (H_BP),
        .V_ACTIVE (V_ACT), .V_FP (V_FP), .V_SYNC (V_SY), .V_BP (V_BP),
        .HS_POL (HS_P), .VS_POL (VS_P), .COLOR_W (1),
        .CELL_LOG2 (CELL), .BAR_LOG2 (BAR), .FRAME_W (8)
    ) dut (
        .clk_i (clk), .rst_ni (rst_n), .pix_en_i (pix_en), .mode_i (mode),
        .fg_rgb_i (fg), .bg_rgb_i (bg), .hsync_o (hsync), .vsync_o (vsync), .de_o (de),
        .red_o (red), .green_o (green), .blue_o (blue),
        .frame_start_o (frame_start), .frame_cnt_o (frame_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected colour of pixel (x,y) straight from the pattern definitions.
    function automatic logic [2:0] ref_rgb(input int x, input int y, input int md, input int frm,
                                           input logic [2:0] f, input logic [2:0] b);
        int xs;
        if (x >= H_ACT || y >= V_ACT) return 3'd0;
        case (md)
            0: return ((((x >> CELL) ^ (y >> CELL)) & 1) != 0) ? f : b;
            1: return 3'(7 - ((x >> BAR) % 8));
            2: return f;
            default: begin
                xs = (x + frm) % XMOD;
                return ((((xs >> CELL) ^ (y >> CELL)) & 1) != 0) ? f : b;
            end
        endcase
    endfunction

    // Reference model: raster position, latched mode, frame count, expected outputs.
    int         m_h = 0, m_v = 0, m_frame = 0, m_mode = 0;
    logic       e_hs = ~HS_P, e_vs = ~VS_P, e_de = 1'b0, e_fs = 1'b0;
    logic [2:0] e_rgb = 3'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_h <= 0; m_v <= 0; m_frame <= 0; m_mode <= 0;
            e_hs <= ~HS_P; e_vs <= ~VS_P; e_de <= 1'b0; e_fs <= 1'b0; e_rgb <= 3'd0;
        end else if (pix_en) begin
            e_hs  <= (m_h >= H_ACT + H_FP && m_h < H_ACT + H_FP + H_SY) ? HS_P : ~HS_P;
            e_vs  <= (m_v >= V_ACT + V_FP && m_v < V_ACT + V_FP + V_SY) ? VS_P : ~VS_P;
            e_de  <= (m_h < H_ACT) && (m_v < V_ACT);
            e_fs  <= (m_h == 0) && (m_v == 0);
            e_rgb <= ref_rgb(m_h, m_v, (m_h == 0 && m_v == 0) ? int'(mode) : m_mode,
                             m_frame, fg, bg);
            if (m_h == 0 && m_v == 0) m_mode <= int'(mode);
            m_h <= (m_h + 1) % H_TOT;
            if (m_h == H_TOT - 1) m_v <= (m_v + 1) % V_TOT;
            if (m_h == H_TOT - 1 && m_v == V_TOT - 1) m_frame <= (m_frame + 1) % 256;
        end
    end

    // Checks outputs at the falling edge, then drives the next strobe.
    task automatic cycle(input logic pe);
        @(negedge clk);
        check_eq("hsync", hsync, e_hs);
        check_eq("vsync", vsync, e_vs);
        check_eq("de", de, e_de);
        check_eq("rgb", {red, green, blue}, e_rgb);
        check_eq("frame_start", frame_start, e_fs);
        check_eq("frame_cnt", frame_cnt, m_frame);
        pix_en = pe;
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_de"}, de, 0);
        check_eq({tag, "_rgb"}, {red, green, blue}, 0);
        check_eq({tag, "_hsync"}, hsync, 1);
        check_eq({tag, "_vsync"}, vsync, 0);
        check_eq({tag, "_fs"}, frame_start, 0);
        check_eq({tag, "_fcnt"}, frame_cnt, 0);
    endtask

    logic [2:0] line0 [8];
    logic [2:0] exp_line0 [8];
    int         hs_cnt, de_cnt;

    initial begin
        exp_line0 = '{3'd1, 3'd1, 3'd7, 3'd7, 3'd1, 3'd1, 3'd7, 3'd7};
        #1 rst_n = 1'b0;
        cycle(1'b0);
        cycle(1'b0);
        check_reset_values("reset");
        rst_n = 1'b1;
        pix_en = 1'b1;

        // First line of checker mode: fixed expectations independent of the model.
        hs_cnt = 0;
        de_cnt = 0;
        for (int i = 0; i < H_TOT; i++) begin
            cycle(1'b1);
            if (i < 8) line0[i] = {red, green, blue};
            if (hsync == HS_P) hs_cnt++;
            if (de) de_cnt++;
        end
        for (int i = 0; i < 8; i++) check_eq($sformatf("line0_px%0d", i), line0[i], exp_line0[i]);
        check_eq("hsync_pulse_len", hs_cnt, H_SY);
        check_eq("de_len", de_cnt, H_ACT);

        for (int i = 0; i < 2 * H_TOT * V_TOT; i++) cycle(1'b1);
        for (int i = 0; i < 200; i++) cycle(i % 2 == 0);

        // Mid-frame switch to bars takes effect at the next frame start.
        for (int i = 0; i < 30; i++) cycle(1'b1);
        mode = 2'd1;
        for (int i = 0; i < 2 * H_TOT * V_TOT; i++) cycle(1'b1);

        mode = 2'd3;
        for (int i = 0; i < 3 * H_TOT * V_TOT; i++) cycle(1'b1);

        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) mode = 2'($urandom);
            if ($urandom_range(0, 19) == 0) fg = 3'($urandom);
            if ($urandom_range(0, 19) == 0) bg = 3'($urandom);
        end

        // Asynchronous reset in the middle of a line.
        mode = 2'd2;
        for (int i = 0; i < 5; i++) cycle(1'b1);
        #2 rst_n = 1'b0;
        #1 check_reset_values("async_rst");
        cycle(1'b0);
        rst_n = 1'b1;
        pix_en = 1'b1;
        cycle(1'b1);
        check_eq("fs_after_rst", frame_start, 1);

        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 1) != 0);
            if ($urandom_range(0, 7) == 0) mode = 2'($urandom);
            if ($urandom_range(0, 15) == 0) fg = 3'($urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
